// File: rtl/pulse_down_counter.sv
// Modulo-N down counter stepped by rising edges of in_pulse, with auto-reload or one-shot modes.
// Optional feature: define INPULSE_SYNC_EN to add a 2-flop synchroniser on in_pulse (+2 clk latency).
module pulse_down_counter #(
    parameter int WIDTH = 4,
    parameter int START = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             in_pulse,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             mode,
    output logic             out_pulse,
    output logic             done,
    output logic [WIDTH-1:0] cur_value
);

    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] START_VAL = WIDTH'(START);
    localparam logic [WIDTH-1:0] START_CNT = WIDTH'(START - 1);

    logic             r_in_q;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_count;
    logic             r_out;
    logic             r_done;

    logic             w_in;
    logic             w_step;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_period_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_out_nxt;
    logic             w_done_nxt;

`ifdef INPULSE_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, so the chain really is two stages.
            r_sync1 <= in_pulse;
            r_sync2 <= r_sync1;
        end
    end

    assign w_in = r_sync2;
`else
    assign w_in = in_pulse;
`endif

    assign w_step         = enable & w_in & ~r_in_q;
    assign w_load_clamped = (load_value == '0) ? ONE : load_value;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_period_nxt = r_period;
        w_count_nxt  = r_count;
        w_out_nxt    = 1'b0;
        w_done_nxt   = mode ? r_done : 1'b0;

        if (load) begin
            w_period_nxt = w_load_clamped;
            w_count_nxt  = w_load_clamped - ONE;
            w_done_nxt   = 1'b0;
        end else if (w_step) begin
            if (r_count != '0) begin
                w_count_nxt = r_count - ONE;
                w_out_nxt   = (r_count == ONE);
                if (mode && (r_count == ONE)) begin
                    w_done_nxt = 1'b1;
                end
            end else if (!mode) begin
                w_count_nxt = r_period - ONE;
                w_out_nxt   = (r_period == ONE);
            end else begin
                // One-shot parked at zero: further steps are absorbed.
                w_done_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_in_q   <= 1'b0;
            r_period <= START_VAL;
            r_count  <= START_CNT;
            r_out    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_in_q   <= w_in;
            r_period <= w_period_nxt;
            r_count  <= w_count_nxt;
            r_out    <= w_out_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign out_pulse = r_out;
    assign done      = r_done;
    assign cur_value = r_count;

endmodule

// File: tb/tb_pulse_down_counter.sv
// Directed self-checking bench for pulse_down_counter (WIDTH=4, START=3).
// Expected outputs are queued when stimulus is driven and compared when the DUT result is sampled.
module tb_pulse_down_counter;

`ifdef INPULSE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [3:0] cur;
        logic       out;
        logic       done;
        string      tag;
    } exp_t;

    logic       clk;
    logic       resetn;
    logic       enable;
    logic       in_pulse;
    logic       load;
    logic [3:0] load_value;
    logic       mode;
    logic       out_pulse;
    logic       done;
    logic [3:0] cur_value;

    exp_t sb[$];
    int   total;
    int   bad;

    pulse_down_counter #(.WIDTH(4), .START(3)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .in_pulse   (in_pulse),
        .load       (load),
        .load_value (load_value),
        .mode       (mode),
        .out_pulse  (out_pulse),
        .done       (done),
        .cur_value  (cur_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [3:0] c, input logic o, input logic d, input string t);
        exp_t e;
        e.cur  = c;
        e.out  = o;
        e.done = d;
        e.tag  = t;
        sb.push_back(e);
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty got=0 entries want>=1");
        end else begin
            e = sb.pop_front();
            total++;
            assert (cur_value === e.cur) else begin
                bad++;
                $error("FAIL %s cur_value got=%0d want=%0d", e.tag, cur_value, e.cur);
            end
            total++;
            assert (out_pulse === e.out) else begin
                bad++;
                $error("FAIL %s out_pulse got=%b want=%b", e.tag, out_pulse, e.out);
            end
            total++;
            assert (done === e.done) else begin
                bad++;
                $error("FAIL %s done got=%b want=%b", e.tag, done, e.done);
            end
        end
    endtask

    // One in_pulse rising edge; checks the step result, then that out_pulse drops next clk.
    task automatic do_edge(input logic [3:0] c, input logic o, input logic d, input string t);
        push_exp(c, o, d, t);
        @(negedge clk) in_pulse = 1'b1;
        repeat (LAT) @(posedge clk);
        #1 compare_pop();
        push_exp(c, 1'b0, d, {t, "_after"});
        @(posedge clk);
        #1 compare_pop();
        @(negedge clk) in_pulse = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] v, input logic [3:0] c, input string t);
        push_exp(c, 1'b0, 1'b0, t);
        @(negedge clk) begin
            load       = 1'b1;
            load_value = v;
        end
        @(posedge clk);
        #1 compare_pop();
        @(negedge clk) load = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        resetn     = 1'b0;
        enable     = 1'b1;
        in_pulse   = 1'b0;
        load       = 1'b0;
        load_value = '0;
        mode       = 1'b0;

        #12;
        push_exp(4'd2, 1'b0, 1'b0, "reset");
        compare_pop();
        @(negedge clk) resetn = 1'b1;

        // Auto-reload, period 3 from reset
        do_edge(4'd1, 1'b0, 1'b0, "t1_e1");
        do_edge(4'd0, 1'b1, 1'b0, "t1_e2");
        do_edge(4'd2, 1'b0, 1'b0, "t1_e3");
        do_edge(4'd1, 1'b0, 1'b0, "t1_e4");
        do_edge(4'd0, 1'b1, 1'b0, "t1_e5");
        do_edge(4'd2, 1'b0, 1'b0, "t1_e6");
        do_edge(4'd1, 1'b0, 1'b0, "t1_e7");

        // Runtime load of period 5
        do_load(4'd5, 4'd4, "t2_load");
        do_edge(4'd3, 1'b0, 1'b0, "t2_e1");
        do_edge(4'd2, 1'b0, 1'b0, "t2_e2");
        do_edge(4'd1, 1'b0, 1'b0, "t2_e3");
        do_edge(4'd0, 1'b1, 1'b0, "t2_e4");
        do_edge(4'd4, 1'b0, 1'b0, "t2_e5");
        do_edge(4'd3, 1'b0, 1'b0, "t2_e6");

        // One-shot, period 3
        @(negedge clk) mode = 1'b1;
        do_load(4'd3, 4'd2, "t3_load");
        do_edge(4'd1, 1'b0, 1'b0, "t3_e1");
        do_edge(4'd0, 1'b1, 1'b1, "t3_e2");
        do_edge(4'd0, 1'b0, 1'b1, "t3_e3");
        do_edge(4'd0, 1'b0, 1'b1, "t3_e4");
        do_edge(4'd0, 1'b0, 1'b1, "t3_e5");
        do_load(4'd3, 4'd2, "t3_load_clears_done");
        @(negedge clk) mode = 1'b0;

        // Load of 0 coincident with a step: clamps to period 1, step discarded
        push_exp(4'd0, 1'b0, 1'b0, "t4_load_step");
        @(negedge clk) in_pulse = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        load       = 1'b1;
        load_value = 4'd0;
        @(posedge clk);
        #1 compare_pop();
        @(negedge clk) load = 1'b0;
        push_exp(4'd0, 1'b0, 1'b0, "t4_hold");
        @(posedge clk);
        #1 compare_pop();
        @(negedge clk) in_pulse = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1;
        do_edge(4'd0, 1'b1, 1'b0, "t4_e1");
        do_edge(4'd0, 1'b1, 1'b0, "t4_e2");
        do_edge(4'd0, 1'b1, 1'b0, "t4_e3");

        // enable low ignores steps; in_pulse held high across enable rise gives no step
        do_load(4'd3, 4'd2, "t5_load");
        @(negedge clk) enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_edge(4'd2, 1'b0, 1'b0, $sformatf("t5_dis%0d", i));
        end
        @(negedge clk) in_pulse = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        enable = 1'b1;
        push_exp(4'd2, 1'b0, 1'b0, "t5_held_high");
        repeat (2) @(posedge clk);
        #1 compare_pop();
        @(negedge clk) in_pulse = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1;
        do_edge(4'd1, 1'b0, 1'b0, "t5_reenabled");

        // Asynchronous reset mid-count, away from any clock edge
        #2 resetn = 1'b0;
        push_exp(4'd2, 1'b0, 1'b0, "t6_async_reset");
        #1 compare_pop();
        @(negedge clk) resetn = 1'b1;

        // Step latency after reset release
        push_exp((LAT == 1) ? 4'd1 : 4'd2, 1'b0, 1'b0, "t6_first_clk");
        @(negedge clk) in_pulse = 1'b1;
        @(posedge clk);
        #1 compare_pop();
        push_exp(4'd1, 1'b0, 1'b0, "t6_after_latency");
        repeat (LAT - 1) @(posedge clk);
        #1 compare_pop();
        @(negedge clk) in_pulse = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1;

        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
